mem_stage: RTL and testbench

//  RV32I MEM stage, directly downstream of the EX/MEM register.
//  - Executes loads and stores on a req/ack data bus.
//  - Aligns load data and sign- or zero-extends it; aligns store data and byte enables.
//  - Stalls the front of the pipeline while an access is outstanding.
//  - Owns the MEM/WB register: every wb_* output is registered.

---
 rtl/rv32_mem_pkg.sv | 15 +
 rtl/mem_lane_align.sv | 48 ++++
 rtl/mem_stage.sv | 161 ++++++++++++++++
 tb/tb_mem_stage.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv32_mem_pkg.sv
// Shared definitions for the RV32I MEM stage: funct3 access codes and FSM state type.
package rv32_mem_pkg;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    typedef enum logic {MS_IDLE, MS_WAIT} mem_state_t;

endpackage

// File: rtl/mem_lane_align.sv
// Combinational lane steering: byte enables, store replication, load extension, alignment check.
module mem_lane_align
    import rv32_mem_pkg::*;
(
    input  logic [2:0]  funct3_i,
    input  logic [1:0]  addr_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] rdata_i,
    output logic [3:0]  be_o,
    output logic [31:0] wdata_o,
    output logic [31:0] rdata_o,
    output logic        misaligned_o
);

    logic        is_byte;
    logic        is_half;
    logic        is_word;
    logic        is_signed;
    logic [31:0] rdata_shifted;

    assign is_byte       = funct3_i inside {F3_LB, F3_LBU, F3_SB};
    assign is_half       = funct3_i inside {F3_LH, F3_LHU, F3_SH};
    assign is_word       = funct3_i inside {F3_LW, F3_SW};
    assign is_signed     = funct3_i inside {F3_LB, F3_LH};
    // Bring the addressed lane down to bit 0 before extension.
    assign rdata_shifted = rdata_i >> {addr_i, 3'b000};

    always_comb begin
        be_o         = 4'b0000;
        wdata_o      = wdata_i;
        rdata_o      = rdata_shifted;
        misaligned_o = 1'b0;
        if (is_byte) begin
            be_o    = 4'b0001 << addr_i;
            wdata_o = {4{wdata_i[7:0]}};
            rdata_o = {{24{is_signed & rdata_shifted[7]}}, rdata_shifted[7:0]};
        end else if (is_half) begin
            be_o         = 4'b0011 << {addr_i[1], 1'b0};
            wdata_o      = {2{wdata_i[15:0]}};
            rdata_o      = {{16{is_signed & rdata_shifted[15]}}, rdata_shifted[15:0]};
            misaligned_o = addr_i[0];
        end else if (is_word) begin
            be_o         = 4'b1111;
            misaligned_o = |addr_i;
        end
    end

endmodule

// File: rtl/mem_stage.sv
// RV32I MEM stage: data-bus access FSM with timeout, fault reporting and the MEM/WB register.
module mem_stage
    import rv32_mem_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  rd_addr_i,
    input  logic [31:0] rd_data_i,
    input  logic        rd_wen_i,
    input  logic        mem_re_i,
    input  logic        mem_we_i,
    input  logic [2:0]  mem_funct3_i,
    input  logic [31:0] mem_wdata_i,
    input  logic [31:0] csr_wdata_i,
    input  logic [31:0] csr_waddr_i,
    input  logic        csr_wen_i,
    output logic        stall_o,
    output logic        dbus_req_o,
    output logic        dbus_we_o,
    output logic [31:0] dbus_addr_o,
    output logic [3:0]  dbus_be_o,
    output logic [31:0] dbus_wdata_o,
    input  logic        dbus_ack_i,
    input  logic [31:0] dbus_rdata_i,
    output logic [4:0]  wb_rd_addr_o,
    output logic [31:0] wb_rd_data_o,
    output logic        wb_rd_wen_o,
    output logic [31:0] wb_csr_wdata_o,
    output logic [31:0] wb_csr_waddr_o,
    output logic        wb_csr_wen_o,
    output logic        mem_fault_o,
    output logic [31:0] mem_fault_addr_o
);

    localparam int unsigned CntW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYCLES - 1);

    mem_state_t      state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            fault_d;
    logic            done;
    logic            bubble;
    logic            mem_op;
    logic            misaligned;
    logic [31:0]     rdata_ext;

    logic [4:0]      wb_rd_addr_q;
    logic [31:0]     wb_rd_data_q;
    logic            wb_rd_wen_q;
    logic [31:0]     wb_csr_wdata_q;
    logic [31:0]     wb_csr_waddr_q;
    logic            wb_csr_wen_q;
    logic            mem_fault_q;
    logic [31:0]     mem_fault_addr_q;

    mem_lane_align u_align (
        .funct3_i     (mem_funct3_i),
        .addr_i       (rd_data_i[1:0]),
        .wdata_i      (mem_wdata_i),
        .rdata_i      (dbus_rdata_i),
        .be_o         (dbus_be_o),
        .wdata_o      (dbus_wdata_o),
        .rdata_o      (rdata_ext),
        .misaligned_o (misaligned)
    );

    assign mem_op      = mem_re_i | mem_we_i;
    assign dbus_we_o   = mem_we_i;
    assign dbus_addr_o = {rd_data_i[31:2], 2'b00};

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        dbus_req_o = 1'b0;
        stall_o    = 1'b0;
        fault_d    = 1'b0;
        done       = 1'b0;
        case (state_q)
            MS_IDLE: begin
                if (mem_op) begin
                    if ((mem_re_i & mem_we_i) | misaligned) begin
                        fault_d = 1'b1;
                    end else begin
                        dbus_req_o = 1'b1;
                        if (dbus_ack_i) begin
                            done = 1'b1;
                        end else begin
                            stall_o = 1'b1;
                            state_d = MS_WAIT;
                            cnt_d   = '0;
                        end
                    end
                end
            end
            MS_WAIT: begin
                if (dbus_ack_i) begin
                    dbus_req_o = 1'b1;
                    done       = 1'b1;
                    state_d    = MS_IDLE;
                    cnt_d      = '0;
                end else if (cnt_q == CntLast) begin
                    // Give up: release the pipeline and report a bus fault.
                    fault_d = 1'b1;
                    state_d = MS_IDLE;
                    cnt_d   = '0;
                end else begin
                    dbus_req_o = 1'b1;
                    stall_o    = 1'b1;
                    cnt_d      = cnt_q + 1'b1;
                end
            end
            default: state_d = MS_IDLE;
        endcase
        if (rst) begin
            dbus_req_o = 1'b0;
            stall_o    = 1'b0;
        end
    end

    assign bubble = stall_o | fault_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q          <= MS_IDLE;
            cnt_q            <= '0;
            wb_rd_addr_q     <= '0;
            wb_rd_data_q     <= '0;
            wb_rd_wen_q      <= 1'b0;
            wb_csr_wdata_q   <= '0;
            wb_csr_waddr_q   <= '0;
            wb_csr_wen_q     <= 1'b0;
            mem_fault_q      <= 1'b0;
            mem_fault_addr_q <= '0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            wb_rd_addr_q   <= rd_addr_i;
            wb_rd_data_q   <= (done & mem_re_i) ? rdata_ext : rd_data_i;
            wb_rd_wen_q    <= rd_wen_i & ~bubble;
            wb_csr_wdata_q <= csr_wdata_i;
            wb_csr_waddr_q <= csr_waddr_i;
            wb_csr_wen_q   <= csr_wen_i & ~bubble;
            mem_fault_q    <= fault_d;
            if (fault_d) begin
                mem_fault_addr_q <= rd_data_i;
            end
        end
    end

    assign wb_rd_addr_o     = wb_rd_addr_q;
    assign wb_rd_data_o     = wb_rd_data_q;
    assign wb_rd_wen_o      = wb_rd_wen_q;
    assign wb_csr_wdata_o   = wb_csr_wdata_q;
    assign wb_csr_waddr_o   = wb_csr_waddr_q;
    assign wb_csr_wen_o     = wb_csr_wen_q;
    assign mem_fault_o      = mem_fault_q;
    assign mem_fault_addr_o = mem_fault_addr_q;

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: ALU pass-through, loads, stores, faults, timeout, reset in WAIT.
module tb_mem_stage;
    import rv32_mem_pkg::*;

    localparam int unsigned Timeout = 16;

    logic        clk;
    logic        rst;
    logic [4:0]  rd_addr_i;
    logic [31:0] rd_data_i;
    logic        rd_wen_i;
    logic        mem_re_i;
    logic        mem_we_i;
    logic [2:0]  mem_funct3_i;
    logic [31:0] mem_wdata_i;
    logic [31:0] csr_wdata_i;
    logic [31:0] csr_waddr_i;
    logic        csr_wen_i;
    logic        stall_o;
    logic        dbus_req_o;
    logic        dbus_we_o;
    logic [31:0] dbus_addr_o;
    logic [3:0]  dbus_be_o;
    logic [31:0] dbus_wdata_o;
    logic        dbus_ack_i;
    logic [31:0] dbus_rdata_i;
    logic [4:0]  wb_rd_addr_o;
    logic [31:0] wb_rd_data_o;
    logic        wb_rd_wen_o;
    logic [31:0] wb_csr_wdata_o;
    logic [31:0] wb_csr_waddr_o;
    logic        wb_csr_wen_o;
    logic        mem_fault_o;
    logic [31:0] mem_fault_addr_o;

    int tests;
    int fails;
    int stall_cnt;

    mem_stage #(.TIMEOUT_CYCLES(Timeout)) dut (
        .clk              (clk),
        .rst              (rst),
        .rd_addr_i        (rd_addr_i),
        .rd_data_i        (rd_data_i),
        .rd_wen_i         (rd_wen_i),
        .mem_re_i         (mem_re_i),
        .mem_we_i         (mem_we_i),
        .mem_funct3_i     (mem_funct3_i),
        .mem_wdata_i      (mem_wdata_i),
        .csr_wdata_i      (csr_wdata_i),
        .csr_waddr_i      (csr_waddr_i),
        .csr_wen_i        (csr_wen_i),
        .stall_o          (stall_o),
        .dbus_req_o       (dbus_req_o),
        .dbus_we_o        (dbus_we_o),
        .dbus_addr_o      (dbus_addr_o),
        .dbus_be_o        (dbus_be_o),
        .dbus_wdata_o     (dbus_wdata_o),
        .dbus_ack_i       (dbus_ack_i),
        .dbus_rdata_i     (dbus_rdata_i),
        .wb_rd_addr_o     (wb_rd_addr_o),
        .wb_rd_data_o     (wb_rd_data_o),
        .wb_rd_wen_o      (wb_rd_wen_o),
        .wb_csr_wdata_o   (wb_csr_wdata_o),
        .wb_csr_waddr_o   (wb_csr_waddr_o),
        .wb_csr_wen_o     (wb_csr_wen_o),
        .mem_fault_o      (mem_fault_o),
        .mem_fault_addr_o (mem_fault_addr_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic set_op(input logic [4:0] rd, input logic [31:0] data, input logic wen,
                          input logic re, input logic we, input logic [2:0] f3,
                          input logic [31:0] wdata, input logic ack, input logic [31:0] rdata);
        rd_addr_i    = rd;
        rd_data_i    = data;
        rd_wen_i     = wen;
        mem_re_i     = re;
        mem_we_i     = we;
        mem_funct3_i = f3;
        mem_wdata_i  = wdata;
        dbus_ack_i   = ack;
        dbus_rdata_i = rdata;
    endtask

    task automatic post_edge();
        @(posedge clk);
        #1;
    endtask

    initial begin
        tests = 0;
        fails = 0;
        rst   = 1'b1;
        csr_wdata_i = 32'h0000_CAFE;
        csr_waddr_i = 32'h0000_0300;
        csr_wen_i   = 1'b1;
        set_op(5'd3, 32'h100, 1'b1, 1'b1, 1'b0, F3_LW, 32'h0, 1'b0, 32'h0);

        // Reset: an aligned load is presented but req/stall must be forced low
        @(negedge clk);
        #1;
        chk("rst_req", 32'(dbus_req_o), 32'h0);
        chk("rst_stall", 32'(stall_o), 32'h0);
        post_edge();
        chk("rst_wb_rd_data", wb_rd_data_o, 32'h0);
        chk("rst_wb_rd_wen", 32'(wb_rd_wen_o), 32'h0);
        chk("rst_wb_csr_wen", 32'(wb_csr_wen_o), 32'h0);
        chk("rst_fault", 32'(mem_fault_o), 32'h0);

        // ALU op with a stray ack that must be ignored
        @(negedge clk);
        rst = 1'b0;
        set_op(5'd5, 32'h1234, 1'b1, 1'b0, 1'b0, 3'b000, 32'h0, 1'b1, 32'hFFFF_FFFF);
        #1;
        chk("alu_stall", 32'(stall_o), 32'h0);
        chk("alu_req", 32'(dbus_req_o), 32'h0);
        post_edge();
        chk("alu_wb_rd_addr", 32'(wb_rd_addr_o), 32'd5);
        chk("alu_wb_rd_data", wb_rd_data_o, 32'h1234);
        chk("alu_wb_rd_wen", 32'(wb_rd_wen_o), 32'h1);
        chk("alu_wb_csr_wdata", wb_csr_wdata_o, 32'h0000_CAFE);
        chk("alu_wb_csr_wen", 32'(wb_csr_wen_o), 32'h1);

        // LB from lane 3, ack same cycle
        @(negedge clk);
        set_op(5'd7, 32'h103, 1'b1, 1'b1, 1'b0, F3_LB, 32'h0, 1'b1, 32'h80FF_FF00);
        #1;
        chk("lb_req", 32'(dbus_req_o), 32'h1);
        chk("lb_stall", 32'(stall_o), 32'h0);
        chk("lb_addr", dbus_addr_o, 32'h100);
        chk("lb_we", 32'(dbus_we_o), 32'h0);
        post_edge();
        chk("lb_wb_data", wb_rd_data_o, 32'hFFFF_FF80);
        chk("lb_wb_wen", 32'(wb_rd_wen_o), 32'h1);

        @(negedge clk);
        set_op(5'd7, 32'h103, 1'b1, 1'b1, 1'b0, F3_LBU, 32'h0, 1'b1, 32'h80FF_FF00);
        post_edge();
        chk("lbu_wb_data", wb_rd_data_o, 32'h0000_0080);

        // Upper halfword, signed then unsigned
        @(negedge clk);
        set_op(5'd8, 32'h102, 1'b1, 1'b1, 1'b0, F3_LH, 32'h0, 1'b1, 32'h8001_0000);
        post_edge();
        chk("lh_wb_data", wb_rd_data_o, 32'hFFFF_8001);
        @(negedge clk);
        set_op(5'd8, 32'h102, 1'b1, 1'b1, 1'b0, F3_LHU, 32'h0, 1'b1, 32'h8001_0000);
        post_edge();
        chk("lhu_wb_data", wb_rd_data_o, 32'h0000_8001);

        // SB to lane 1
        @(negedge clk);
        set_op(5'd0, 32'h001, 1'b0, 1'b0, 1'b1, F3_SB, 32'h1234_565A, 1'b1, 32'h0);
        #1;
        chk("sb_be", 32'(dbus_be_o), 32'h2);
        chk("sb_wdata", dbus_wdata_o, 32'h5A5A_5A5A);
        chk("sb_we", 32'(dbus_we_o), 32'h1);
        chk("sb_addr", dbus_addr_o, 32'h0);

        // SH acked on the fourth cycle: three stalled cycles, three bubbles
        @(negedge clk);
        set_op(5'd6, 32'h202, 1'b1, 1'b0, 1'b1, F3_SH, 32'h0000_ABCD, 1'b0, 32'h0);
        for (int i = 0; i < 3; i++) begin
            #1;
            chk($sformatf("sh_stall_%0d", i), 32'(stall_o), 32'h1);
            chk($sformatf("sh_req_%0d", i), 32'(dbus_req_o), 32'h1);
            chk($sformatf("sh_be_%0d", i), 32'(dbus_be_o), 32'hC);
            chk($sformatf("sh_wdata_%0d", i), dbus_wdata_o, 32'hABCD_ABCD);
            chk($sformatf("sh_addr_%0d", i), dbus_addr_o, 32'h200);
            post_edge();
            chk($sformatf("sh_bubble_rd_%0d", i), 32'(wb_rd_wen_o), 32'h0);
            chk($sformatf("sh_bubble_csr_%0d", i), 32'(wb_csr_wen_o), 32'h0);
            @(negedge clk);
        end
        dbus_ack_i = 1'b1;
        #1;
        chk("sh_ack_stall", 32'(stall_o), 32'h0);
        chk("sh_ack_req", 32'(dbus_req_o), 32'h1);
        post_edge();
        chk("sh_done_wen", 32'(wb_rd_wen_o), 32'h1);
        chk("sh_done_csr_wen", 32'(wb_csr_wen_o), 32'h1);
        chk("sh_fault", 32'(mem_fault_o), 32'h0);

        // Misaligned LW: no request, no stall, fault pulse next cycle
        @(negedge clk);
        set_op(5'd4, 32'h101, 1'b1, 1'b1, 1'b0, F3_LW, 32'h0, 1'b0, 32'h0);
        #1;
        chk("mis_req", 32'(dbus_req_o), 32'h0);
        chk("mis_stall", 32'(stall_o), 32'h0);
        post_edge();
        chk("mis_fault", 32'(mem_fault_o), 32'h1);
        chk("mis_fault_addr", mem_fault_addr_o, 32'h101);
        chk("mis_wb_wen", 32'(wb_rd_wen_o), 32'h0);

        // re and we together on an aligned word
        @(negedge clk);
        set_op(5'd4, 32'h100, 1'b1, 1'b1, 1'b1, F3_LW, 32'h0, 1'b0, 32'h0);
        #1;
        chk("both_req", 32'(dbus_req_o), 32'h0);
        post_edge();
        chk("both_fault", 32'(mem_fault_o), 32'h1);
        chk("both_fault_addr", mem_fault_addr_o, 32'h100);

        // LW never acked: stall for Timeout cycles, then abort
        @(negedge clk);
        set_op(5'd10, 32'h300, 1'b1, 1'b1, 1'b0, F3_LW, 32'h0, 1'b0, 32'h0);
        stall_cnt = 0;
        for (int i = 0; i < 40; i++) begin
            #1;
            if (stall_o !== 1'b1) break;
            stall_cnt++;
            @(negedge clk);
        end
        chk("to_stall_cycles", 32'(stall_cnt), 32'(Timeout));
        chk("to_req_dropped", 32'(dbus_req_o), 32'h0);
        post_edge();
        chk("to_fault", 32'(mem_fault_o), 32'h1);
        chk("to_fault_addr", mem_fault_addr_o, 32'h300);
        chk("to_wb_wen", 32'(wb_rd_wen_o), 32'h0);

        // Reset while in WAIT aborts the access silently
        @(negedge clk);
        set_op(5'd11, 32'h400, 1'b1, 1'b1, 1'b0, F3_LW, 32'h0, 1'b0, 32'h0);
        #1;
        chk("rw_idle_req", 32'(dbus_req_o), 32'h1);
        post_edge();
        chk("to_fault_pulse_end", 32'(mem_fault_o), 32'h0);
        @(negedge clk);
        #1;
        chk("rw_wait_stall", 32'(stall_o), 32'h1);
        rst = 1'b1;
        #1;
        chk("rw_rst_req", 32'(dbus_req_o), 32'h0);
        chk("rw_rst_stall", 32'(stall_o), 32'h0);
        post_edge();
        chk("rw_wb_rd_addr", 32'(wb_rd_addr_o), 32'h0);
        chk("rw_wb_rd_data", wb_rd_data_o, 32'h0);
        chk("rw_wb_csr_wdata", wb_csr_wdata_o, 32'h0);
        chk("rw_wb_csr_waddr", wb_csr_waddr_o, 32'h0);
        chk("rw_fault", 32'(mem_fault_o), 32'h0);

        @(negedge clk);
        rst = 1'b0;
        set_op(5'd9, 32'h404, 1'b1, 1'b1, 1'b0, F3_LW, 32'h0, 1'b1, 32'hDEAD_BEEF);
        #1;
        chk("post_rst_stall", 32'(stall_o), 32'h0);
        chk("post_rst_req", 32'(dbus_req_o), 32'h1);
        chk("post_rst_addr", dbus_addr_o, 32'h404);
        post_edge();
        chk("post_rst_wb_data", wb_rd_data_o, 32'hDEAD_BEEF);
        chk("post_rst_wb_addr", 32'(wb_rd_addr_o), 32'd9);
        chk("post_rst_wb_wen", 32'(wb_rd_wen_o), 32'h1);
        chk("post_rst_fault", 32'(mem_fault_o), 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
